// File: rtl/vga_pkg.sv
// Shared types and default geometry for the tile line-buffer fill path.
package vga_pkg;

  localparam int unsigned DefTilesPerLine = 160;
  localparam int unsigned DefTileRows     = 120;
  localparam int unsigned DefPxlWidth     = 12;
  localparam int unsigned DefMemRdLat     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } fill_state_e;

  // Recognisable diagnostic pixel: row nibble framing the column nibble.
  function automatic logic [11:0] test_pattern(logic [3:0] row, logic [3:0] col);
    return {row, col, row};
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid-qualified shift register matching the frame-memory read latency.
module rd_lat_pipe #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  logic [Depth-1:0] vld_q;
  logic [Width-1:0] dat_q [Depth];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[Depth-1];
  assign data_o  = dat_q[Depth-1];
  assign empty_o = ~|vld_q;

endmodule

// File: rtl/line_buff_fill_sched.sv
// Schedules line-buffer fills from frame memory and arbitrates host writes.
// Define TEST_PATTERN_EN to fill from a generated pattern instead of memory.
module line_buff_fill_sched
  import vga_pkg::*;
#(
  parameter int unsigned TILES_PER_LINE = DefTilesPerLine,
  parameter int unsigned TILE_ROWS      = DefTileRows,
  parameter int unsigned PXL_WIDTH      = DefPxlWidth,
  parameter int unsigned MEM_RD_LAT     = DefMemRdLat,
  parameter int unsigned ADDR_WIDTH     = $clog2(TILES_PER_LINE * TILE_ROWS)
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [1:0]                        buff_fill_req_i,
  output logic [1:0]                        buff_fill_done_o,
  input  logic                              frame_start_i,
  input  logic                              host_wr_req_i,
  input  logic [ADDR_WIDTH-1:0]             host_wr_addr_i,
  input  logic [PXL_WIDTH-1:0]              host_wr_data_i,
  output logic                              host_wr_gnt_o,
  output logic                              mem_en_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [PXL_WIDTH-1:0]              mem_wdata_o,
  input  logic [PXL_WIDTH-1:0]              mem_rdata_i,
  output logic [1:0]                        lbuf_we_o,
  output logic [$clog2(TILES_PER_LINE)-1:0] lbuf_addr_o,
  output logic [PXL_WIDTH-1:0]              lbuf_wdata_o,
  output logic                              busy_o
);

  localparam int unsigned ColW = $clog2(TILES_PER_LINE);
  localparam int unsigned RowW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam int unsigned PayW = ColW + 1;

  fill_state_e     state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [RowW-1:0] fill_row_q, fill_row_d;
  logic            buf_q, buf_d;
  logic [1:0]      pend_q, pend_d;
  logic            fs_seen_q, fs_seen_d;
  logic [1:0]      pend_all;
  logic            fill_rd;

  logic            pipe_vld, pipe_empty, pipe_buf;
  logic [PayW-1:0] pipe_dat;
  logic [ColW-1:0] pipe_col;

  assign pend_all = pend_q | buff_fill_req_i;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    fill_row_d = fill_row_q;
    buf_d      = buf_q;
    pend_d     = pend_all;
    fs_seen_d  = fs_seen_q | frame_start_i;
    fill_rd    = 1'b0;
    if (frame_start_i) row_d = '0;
    unique case (state_q)
      StIdle: begin
        fs_seen_d = 1'b0;
        if (|pend_all) begin
          state_d    = StRead;
          col_d      = '0;
          fill_row_d = frame_start_i ? '0 : row_q;
          if (pend_all[0]) begin
            buf_d     = 1'b0;
            pend_d[0] = 1'b0;
          end else begin
            buf_d     = 1'b1;
            pend_d[1] = 1'b0;
          end
        end
      end
      StRead: begin
        fill_rd = 1'b1;
        if (col_q == ColW'(TILES_PER_LINE - 1)) begin
          state_d = StDrain;
          col_d   = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StDrain: begin
        if (pipe_empty) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        // A frame start seen at any point during this fill restarts the frame.
        if (frame_start_i || fs_seen_q) begin
          row_d = '0;
        end else if (fill_row_q == RowW'(TILE_ROWS - 1)) begin
          row_d = '0;
        end else begin
          row_d = fill_row_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      fill_row_q <= '0;
      buf_q      <= 1'b0;
      pend_q     <= '0;
      fs_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fill_row_q <= fill_row_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      fs_seen_q  <= fs_seen_d;
    end
  end

  rd_lat_pipe #(
    .Depth (MEM_RD_LAT),
    .Width (PayW)
  ) u_rd_lat_pipe (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (fill_rd),
    .data_i  ({buf_q, col_q}),
    .valid_o (pipe_vld),
    .data_o  (pipe_dat),
    .empty_o (pipe_empty)
  );

  assign {pipe_buf, pipe_col} = pipe_dat;

  logic                  mem_rd;
  logic                  host_gnt;
  logic [ADDR_WIDTH-1:0] fill_addr;

  assign fill_addr = ADDR_WIDTH'(fill_row_q) * ADDR_WIDTH'(TILES_PER_LINE) + ADDR_WIDTH'(col_q);

`ifdef TEST_PATTERN_EN
  assign mem_rd = 1'b0;
`else
  assign mem_rd = fill_rd;
`endif

  // Reset gates the grant so a host request held through reset stays invisible.
  assign host_gnt      = host_wr_req_i & ~mem_rd & rstn_i;
  assign host_wr_gnt_o = host_gnt;

  always_comb begin
    mem_en_o    = mem_rd | host_gnt;
    mem_we_o    = host_gnt;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_rd) begin
      mem_addr_o = fill_addr;
    end else if (host_gnt) begin
      mem_addr_o  = host_wr_addr_i;
      mem_wdata_o = host_wr_data_i;
    end
  end

  always_comb begin
    lbuf_we_o    = 2'b00;
    lbuf_addr_o  = '0;
    lbuf_wdata_o = '0;
    if (pipe_vld) begin
      lbuf_we_o   = pipe_buf ? 2'b10 : 2'b01;
      lbuf_addr_o = pipe_col;
`ifdef TEST_PATTERN_EN
      lbuf_wdata_o = PXL_WIDTH'(test_pattern(4'(fill_row_q), 4'(pipe_col)));
`else
      lbuf_wdata_o = mem_rdata_i;
`endif
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign buff_fill_done_o = (state_q == StDone) ? (buf_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_line_buff_fill_sched.sv
// Randomised bench for line_buff_fill_sched against a timeline model of each fill.
module tb_line_buff_fill_sched;

  localparam int TPL = 160;
  localparam int ROWS = 120;
  localparam int PW = 12;
  localparam int LAT = 2;
  localparam int AW = 15;
  localparam int CW = 8;
  localparam int MSZ = TPL * ROWS;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [1:0]    buff_fill_req_i = '0;
  logic [1:0]    buff_fill_done_o;
  logic          frame_start_i = 1'b0;
  logic          host_wr_req_i = 1'b0;
  logic [AW-1:0] host_wr_addr_i = '0;
  logic [PW-1:0] host_wr_data_i = '0;
  logic          host_wr_gnt_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [PW-1:0] mem_wdata_o;
  logic [PW-1:0] mem_rdata_i;
  logic [1:0]    lbuf_we_o;
  logic [CW-1:0] lbuf_addr_o;
  logic [PW-1:0] lbuf_wdata_o;
  logic          busy_o;

  line_buff_fill_sched #(
    .TILES_PER_LINE (TPL),
    .TILE_ROWS      (ROWS),
    .PXL_WIDTH      (PW),
    .MEM_RD_LAT     (LAT),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .buff_fill_req_i  (buff_fill_req_i),
    .buff_fill_done_o (buff_fill_done_o),
    .frame_start_i    (frame_start_i),
    .host_wr_req_i    (host_wr_req_i),
    .host_wr_addr_i   (host_wr_addr_i),
    .host_wr_data_i   (host_wr_data_i),
    .host_wr_gnt_o    (host_wr_gnt_o),
    .mem_en_o         (mem_en_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rdata_i      (mem_rdata_i),
    .lbuf_we_o        (lbuf_we_o),
    .lbuf_addr_o      (lbuf_addr_o),
    .lbuf_wdata_o     (lbuf_wdata_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Frame memory with MEM_RD_LAT read latency; returns noise when not reading.
  logic [PW-1:0] mem [MSZ];
  logic [PW-1:0] rpipe [LAT];
  initial for (int i = 0; i < MSZ; i++) mem[i] = PW'($urandom);

  always @(posedge clk_i) begin
    if (mem_en_o && !mem_we_o && int'(mem_addr_o) < MSZ) rpipe[0] <= mem[mem_addr_o];
    else rpipe[0] <= PW'($urandom);
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    if (mem_en_o && mem_we_o && int'(mem_addr_o) < MSZ) mem[mem_addr_o] <= mem_wdata_o;
  end
  assign mem_rdata_i = rpipe[LAT-1];

  // Fill model: a fill decided in cycle d reads col k in d+1+k, writes it LAT later,
  // and signals done in d+TPL+LAT+2.
  bit         m_active = 0;
  int         m_d = 0;
  bit         m_buf = 0;
  int         m_row = 0;
  int         m_next_row = 0;
  bit         m_fs_since = 0;
  logic [1:0] m_pend = '0;

  int done_cnt = 0, last_done_cyc = 0, last_done_val = 0;
  int done_first_addr = 0, done_last_addr = 0;
  int cur_first = 0, last_rd = 0, wr_a_cnt = 0, gnt_busy_cnt = 0;
  bit prev_rd = 0;

  always @(negedge clk_i) begin : compare
    logic          e_rd, e_wr, e_done, e_busy, e_gnt, e_en, e_mrd, was_active;
    int            e_col_rd, e_col_wr;
    logic [1:0]    e_lwe, e_done_v;
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_wdata, e_lwdata;

    e_rd = 0; e_wr = 0; e_done = 0; e_busy = 0; e_gnt = 0; e_en = 0; e_mrd = 0;
    e_col_rd = 0; e_col_wr = 0; e_lwe = '0; e_done_v = '0; e_addr = '0;
    e_wdata = '0; e_lwdata = '0;
    if (!rstn_i) begin
      m_active = 0; m_pend = '0; m_next_row = 0; m_row = 0; m_fs_since = 0;
    end else begin
      e_rd     = m_active && cyc >= m_d + 1 && cyc <= m_d + TPL;
      e_wr     = m_active && cyc >= m_d + 1 + LAT && cyc <= m_d + TPL + LAT;
      e_done   = m_active && cyc == m_d + TPL + LAT + 2;
      e_busy   = m_active && cyc > m_d;
      e_col_rd = cyc - m_d - 1;
      e_col_wr = cyc - m_d - 1 - LAT;
`ifdef TEST_PATTERN_EN
      e_mrd = 0;
`else
      e_mrd = e_rd;
`endif
      e_gnt    = host_wr_req_i && !e_mrd;
      e_en     = e_mrd || e_gnt;
      e_addr   = e_mrd ? AW'(m_row * TPL + e_col_rd) : host_wr_addr_i;
      e_wdata  = host_wr_data_i;
      e_lwe    = e_wr ? (m_buf ? 2'b10 : 2'b01) : 2'b00;
      e_done_v = e_done ? (m_buf ? 2'b10 : 2'b01) : 2'b00;
`ifdef TEST_PATTERN_EN
      e_lwdata = PW'({4'(m_row), 4'(e_col_wr), 4'(m_row)});
`else
      e_lwdata = mem_rdata_i;
`endif
    end

    chk("busy", busy_o, e_busy);
    chk("done", buff_fill_done_o, e_done_v);
    chk("gnt", host_wr_gnt_o, e_gnt);
    chk("mem_en", mem_en_o, e_en);
    chk("mem_we", mem_we_o, e_gnt);
    chk("lbuf_we", lbuf_we_o, e_lwe);
    if (e_en) chk("mem_addr", mem_addr_o, e_addr);
    if (e_gnt) chk("mem_wdata", mem_wdata_o, e_wdata);
    if (e_wr) begin
      chk("lbuf_addr", lbuf_addr_o, e_col_wr);
      chk("lbuf_wdata", lbuf_wdata_o, e_lwdata);
    end
    if (!rstn_i) begin
      chk("rst_quiet", {mem_addr_o, mem_wdata_o, lbuf_addr_o, lbuf_wdata_o}, 0);
    end

    // Observations used by the scenario checks.
    if (rstn_i) begin
      if (mem_en_o && !mem_we_o) begin
        if (!prev_rd) cur_first = int'(mem_addr_o);
        last_rd = int'(mem_addr_o);
        prev_rd = 1;
      end else begin
        prev_rd = 0;
      end
      if (|buff_fill_done_o) begin
        done_cnt++;
        last_done_cyc   = cyc;
        last_done_val   = buff_fill_done_o;
        done_first_addr = cur_first;
        done_last_addr  = last_rd;
      end
      if (lbuf_we_o == 2'b01) wr_a_cnt++;
      if (host_wr_gnt_o && busy_o) gnt_busy_cnt++;

      was_active = m_active;
      if (e_done) begin
        m_next_row = (frame_start_i || m_fs_since) ? 0 : (m_row + 1) % ROWS;
        m_active   = 0;
      end else if (frame_start_i) begin
        m_next_row = 0;
        if (m_active) m_fs_since = 1;
      end
      m_pend = m_pend | buff_fill_req_i;
      if (!was_active && m_pend != 2'b00) begin
        m_buf = !m_pend[0];
        if (m_pend[0]) m_pend[0] = 1'b0;
        else m_pend[1] = 1'b0;
        m_row      = frame_start_i ? 0 : m_next_row;
        m_d        = cyc;
        m_active   = 1;
        m_fs_since = 0;
      end
    end else begin
      prev_rd = 0;
    end
    cyc++;
  end

  // 0: idle, 1: held high, 2: random.
  int host_mode = 0;
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      host_wr_req_i  = (host_mode == 1) || (host_mode == 2 && $urandom_range(0, 1) == 1);
      host_wr_addr_i = AW'($urandom_range(0, MSZ - 1));
      host_wr_data_i = PW'($urandom);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    buff_fill_req_i = '0;
    frame_start_i = 1'b0;
    repeat (3) step();
    rstn_i = 1'b1;
    step();
  endtask

  task automatic fill(input logic [1:0] bits, output int rq);
    buff_fill_req_i = bits;
    rq = cyc;
    step();
    buff_fill_req_i = '0;
  endtask

  task automatic wait_done(input int bound);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < bound) begin
      step();
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done pulse, required one within %0d cycles", bound);
    end
  endtask

  initial begin
    int rq, w0, g0, d0, n;

    // Request A right after reset.
    do_reset();
    w0 = wr_a_cnt;
    fill(2'b01, rq);
    wait_done(400);
    chk("s1_latency", last_done_cyc - rq, 164);
    chk("s1_done_val", last_done_val, 1);
    chk("s1_a_writes", wr_a_cnt - w0, 160);
`ifndef TEST_PATTERN_EN
    chk("s1_first_addr", done_first_addr, 0);
    chk("s1_last_addr", done_last_addr, 159);
`endif

    // Both requests in one cycle: A first, then B on the next row.
    do_reset();
    fill(2'b11, rq);
    wait_done(400);
    chk("s2_first_done", last_done_val, 1);
`ifndef TEST_PATTERN_EN
    chk("s2_a_row0", done_first_addr, 0);
`endif
    wait_done(400);
    chk("s2_second_done", last_done_val, 2);
`ifndef TEST_PATTERN_EN
    chk("s2_b_row1", done_first_addr, 160);
`endif

    // Host write held high through a fill: only DRAIN and DONE cycles grant.
    repeat (5) step();
    host_mode = 1;
    g0 = gnt_busy_cnt;
    fill(2'b10, rq);
    wait_done(400);
    chk("s3_gnt_while_busy", gnt_busy_cnt - g0, LAT + 2);
    host_mode = 2;
    repeat (5) step();

    // 120 consecutive fills wrap the row pointer.
    do_reset();
    for (int k = 0; k < ROWS; k++) begin
      fill($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01, rq);
      wait_done(400);
`ifndef TEST_PATTERN_EN
      if (k == ROWS - 1) chk("s4_last_row", done_first_addr, (ROWS - 1) * TPL);
`endif
    end
    fill(2'b01, rq);
    wait_done(400);
`ifndef TEST_PATTERN_EN
    chk("s4_wrap", done_first_addr, 0);
`endif

    // Frame start mid-fill at row 5.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fill(2'b01, rq);
      wait_done(400);
    end
    fill(2'b10, rq);
    repeat (50) step();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    wait_done(400);
`ifndef TEST_PATTERN_EN
    chk("s5_row5", done_first_addr, 5 * TPL);
`endif
    fill(2'b01, rq);
    wait_done(400);
`ifndef TEST_PATTERN_EN
    chk("s5_row0", done_first_addr, 0);
`endif

    // Reset at col 80 aborts the fill.
    do_reset();
    fill(2'b01, rq);
    n = 0;
    while (!(mem_en_o && !mem_we_o && mem_addr_o == AW'(80)) && n < 300) begin
      step();
      n++;
    end
`ifndef TEST_PATTERN_EN
    chk("s6_reached_col80", int'(mem_addr_o), 80);
`endif
    rstn_i = 1'b0;
    #1;
    chk("s6_outputs_zero",
        {buff_fill_done_o, host_wr_gnt_o, mem_en_o, mem_we_o, lbuf_we_o, busy_o}, 0);
    repeat (3) step();
    rstn_i = 1'b1;
    d0 = done_cnt;
    repeat (20) step();
    chk("s6_no_done", done_cnt - d0, 0);
    fill(2'b01, rq);
    wait_done(400);
    chk("s6_refill_done", last_done_val, 1);
    chk("s6_refill_latency", last_done_cyc - rq, 164);
`ifndef TEST_PATTERN_EN
    chk("s6_refill_col0", done_first_addr, 0);
`endif

    // Random traffic against the model.
    host_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      buff_fill_req_i = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      frame_start_i   = ($urandom_range(0, 249) == 0);
      step();
    end
    buff_fill_req_i = '0;
    frame_start_i = 1'b0;
    repeat (400) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
